// File: rtl/instruction_queue.sv
// Circular word FIFO that presents its head as a decoded instruction; a head word
// with its MSB set is a long instruction whose immediate is the following word.
module instruction_queue #(
    parameter int WIDTH    = 16,
    parameter int OPCODE_W = 7,
    parameter int OPER_W   = 3,
    parameter int DEPTH    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         notLoad,
    input  logic [WIDTH-1:0]             data,
    input  logic                         next,
    input  logic                         flush,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         valid,
    output logic                         isLong,
    output logic [OPCODE_W-1:0]          opcode,
    output logic [OPER_W-1:0]            op0,
    output logic [OPER_W-1:0]            op1,
    output logic [OPER_W-1:0]            op2,
    output logic [WIDTH-1:0]             imm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (OPCODE_W + 3 * OPER_W != WIDTH) begin : g_bad_layout
        $error("instruction_queue: OPCODE_W + 3*OPER_W must equal WIDTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instruction_queue: DEPTH must be a power of two, at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] head_word;
    logic [WIDTH-1:0] imm_word;
    logic             head_long;
    logic             head_valid;
    logic             pop;
    logic             push_ok;
    logic             wr_en;
    logic [CNT_W-1:0] pop_size;
    logic [CNT_W-1:0] count_after_pop;

    // A long head needs its immediate queued behind it before it is usable.
    assign head_word  = mem_q[rd_ptr_q];
    assign imm_word   = mem_q[rd_ptr_q + PTR_W'(1)];
    assign head_long  = head_word[WIDTH-1];
    assign head_valid = head_long ? (count_q >= CNT_W'(2)) : (count_q != '0);

    always_comb begin : next_state
        // NOTE: every signal driven here gets a default first, so no path through the
        // if/else can leave one unassigned and infer a latch.
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        wr_en           = 1'b0;
        pop             = next && head_valid;
        pop_size        = pop ? (head_long ? CNT_W'(2) : CNT_W'(1)) : '0;
        count_after_pop = count_q - pop_size;
        push_ok         = !notLoad && (count_after_pop < DEPTH_C);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_en    = push_ok;
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_size);
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d  = count_after_pop + {{(CNT_W-1){1'b0}}, push_ok};
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone
    // decide which entries are live, so stale words are never observed.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign full   = (count_q == DEPTH_C);
    assign count  = count_q;
    assign valid  = head_valid;
    assign isLong = head_valid && head_long;
    assign opcode = head_valid ? head_word[WIDTH-1 -: OPCODE_W]  : '0;
    assign op0    = head_valid ? head_word[3*OPER_W-1 -: OPER_W] : '0;
    assign op1    = head_valid ? head_word[2*OPER_W-1 -: OPER_W] : '0;
    assign op2    = head_valid ? head_word[OPER_W-1:0]           : '0;
    assign imm    = (head_valid && head_long) ? imm_word : '0;

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: a directed vector table for the documented scenarios,
// then random traffic compared against a queue-based reference model.
module tb_instruction_queue;

    localparam int WIDTH    = 16;
    localparam int OPCODE_W = 7;
    localparam int OPER_W   = 3;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                notLoad = 1'b1;
    logic [WIDTH-1:0]    data = '0;
    logic                next = 1'b0;
    logic                flush = 1'b0;
    logic                full;
    logic [CNT_W-1:0]    count;
    logic                valid;
    logic                isLong;
    logic [OPCODE_W-1:0] opcode;
    logic [OPER_W-1:0]   op0, op1, op2;
    logic [WIDTH-1:0]    imm;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_q[$];

    instruction_queue #(
        .WIDTH(WIDTH), .OPCODE_W(OPCODE_W), .OPER_W(OPER_W), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .notLoad(notLoad), .data(data),
        .next(next), .flush(flush), .full(full), .count(count), .valid(valid),
        .isLong(isLong), .opcode(opcode), .op0(op0), .op1(op1), .op2(op2), .imm(imm)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst, nld;
        logic [15:0] din;
        logic        nxt, fl;
        logic [2:0]  cnt;
        logic        full, vld, lng;
        logic [6:0]  opc;
        logic [2:0]  o0, o1, o2;
        logic [15:0] imm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(string name, logic rst, logic nld, logic [15:0] din,
                               logic nxt, logic fl, logic [2:0] cnt, logic fu,
                               logic vld, logic lng, logic [6:0] opc, logic [2:0] o0,
                               logic [2:0] o1, logic [2:0] o2, logic [15:0] im);
        vec_t r;
        r.name = name; r.rst = rst; r.nld = nld; r.din = din; r.nxt = nxt; r.fl = fl;
        r.cnt = cnt; r.full = fu; r.vld = vld; r.lng = lng; r.opc = opc;
        r.o0 = o0; r.o1 = o1; r.o2 = o2; r.imm = im;
        return r;
    endfunction

    // Expected outputs all zero except count (no valid head).
    function automatic vec_t vz(string name, logic rst, logic nld, logic [15:0] din,
                                logic nxt, logic fl, logic [2:0] cnt);
        return v(name, rst, nld, din, nxt, fl, cnt, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] e_cnt, input logic e_full,
                                 input logic e_vld, input logic e_lng, input logic [6:0] e_opc,
                                 input logic [2:0] e_o0, input logic [2:0] e_o1,
                                 input logic [2:0] e_o2, input logic [15:0] e_imm);
        check($sformatf("%s.count", tag),  32'(count),  32'(e_cnt));
        check($sformatf("%s.full", tag),   32'(full),   32'(e_full));
        check($sformatf("%s.valid", tag),  32'(valid),  32'(e_vld));
        check($sformatf("%s.isLong", tag), 32'(isLong), 32'(e_lng));
        check($sformatf("%s.opcode", tag), 32'(opcode), 32'(e_opc));
        check($sformatf("%s.op0", tag),    32'(op0),    32'(e_o0));
        check($sformatf("%s.op1", tag),    32'(op1),    32'(e_o1));
        check($sformatf("%s.op2", tag),    32'(op2),    32'(e_o2));
        check($sformatf("%s.imm", tag),    32'(imm),    32'(e_imm));
    endtask

    function automatic bit model_head_valid();
        if (model_q.size() == 0) return 1'b0;
        if (model_q[0][15]) return model_q.size() >= 2;
        return 1'b1;
    endfunction

    // One rising edge of the reference queue, decided from pre-edge contents.
    function automatic void model_edge(logic rst, logic nld, logic [15:0] din, logic nxt, logic fl);
        int pop_n;
        if (rst || fl) begin
            model_q.delete();
            return;
        end
        pop_n = 0;
        if (nxt && model_head_valid()) pop_n = model_q[0][15] ? 2 : 1;
        for (int i = 0; i < pop_n; i++) void'(model_q.pop_front());
        if (!nld && model_q.size() < DEPTH) model_q.push_back(din);
    endfunction

    task automatic check_model(input string tag);
        bit          hv;
        logic [15:0] head;
        logic [15:0] e_imm;
        logic        e_lng;
        hv    = model_head_valid();
        head  = hv ? model_q[0] : 16'h0;
        e_lng = hv && model_q[0][15];
        e_imm = e_lng ? model_q[1] : 16'h0;
        check_outputs(tag, 3'(model_q.size()), model_q.size() == DEPTH, hv, e_lng,
                      7'(head >> 9), 3'((head >> 6) & 16'h7), 3'((head >> 3) & 16'h7),
                      3'(head & 16'h7), e_imm);
    endtask

    task automatic step(input logic rst, input logic nld, input logic [15:0] din,
                        input logic nxt, input logic fl);
        @(negedge clock);
        reset = rst; notLoad = nld; data = din; next = nxt; flush = fl;
        model_edge(rst, nld, din, nxt, fl);
        @(posedge clock);
        #1;
    endtask

    localparam logic [15:0] WA = 16'h0201, WB = 16'h0402, WC = 16'h0603,
                            WD = 16'h0804, WE = 16'h0A05;

    initial begin
        //               name             rst nld din      nxt fl  cnt fu vld lng opc    o0 o1 o2 imm
        vecs.push_back(vz("reset",        1, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(v ("short_push",   0, 0, 16'h5773, 0, 0, 1, 0, 1, 0, 7'h2B, 5, 6, 3, 16'h0));
        vecs.push_back(vz("short_pop",    0, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(vz("next_empty",   0, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(vz("long_half",    0, 0, 16'hAF73, 0, 0, 1));
        vecs.push_back(vz("long_next_ign",0, 1, 16'h0000, 1, 0, 1));
        vecs.push_back(v ("long_imm",     0, 0, 16'h1234, 0, 0, 2, 0, 1, 1, 7'h57, 5, 6, 3, 16'h1234));
        vecs.push_back(vz("long_pop",     0, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(v ("push_a",       0, 0, WA,       0, 0, 1, 0, 1, 0, 7'd1, 0, 0, 1, 16'h0));
        vecs.push_back(v ("push_b",       0, 0, WB,       0, 0, 2, 0, 1, 0, 7'd1, 0, 0, 1, 16'h0));
        vecs.push_back(v ("push_c",       0, 0, WC,       0, 0, 3, 0, 1, 0, 7'd1, 0, 0, 1, 16'h0));
        vecs.push_back(v ("push_d_full",  0, 0, WD,       0, 0, 4, 1, 1, 0, 7'd1, 0, 0, 1, 16'h0));
        vecs.push_back(v ("push_e_drop",  0, 0, WE,       0, 0, 4, 1, 1, 0, 7'd1, 0, 0, 1, 16'h0));
        vecs.push_back(v ("push_pop_full",0, 0, WE,       1, 0, 4, 1, 1, 0, 7'd2, 0, 0, 2, 16'h0));
        vecs.push_back(v ("pop_b",        0, 1, 16'h0000, 1, 0, 3, 0, 1, 0, 7'd3, 0, 0, 3, 16'h0));
        vecs.push_back(v ("pop_c",        0, 1, 16'h0000, 1, 0, 2, 0, 1, 0, 7'd4, 0, 0, 4, 16'h0));
        vecs.push_back(v ("pop_d",        0, 1, 16'h0000, 1, 0, 1, 0, 1, 0, 7'd5, 0, 0, 5, 16'h0));
        vecs.push_back(vz("pop_e",        0, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(v ("fl_fill1",     0, 0, 16'h5773, 0, 0, 1, 0, 1, 0, 7'h2B, 5, 6, 3, 16'h0));
        vecs.push_back(v ("fl_fill2",     0, 0, WA,       0, 0, 2, 0, 1, 0, 7'h2B, 5, 6, 3, 16'h0));
        vecs.push_back(v ("fl_fill3",     0, 0, WB,       0, 0, 3, 0, 1, 0, 7'h2B, 5, 6, 3, 16'h0));
        vecs.push_back(vz("flush_all",    0, 0, WC,       1, 1, 0));
        vecs.push_back(vz("flush_after",  0, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(vz("rst_half",     0, 0, 16'hAF73, 0, 0, 1));
        vecs.push_back(vz("rst_with_push",1, 0, 16'h1234, 0, 0, 0));
        vecs.push_back(v ("rst_then_push",0, 0, 16'h0001, 0, 0, 1, 0, 1, 0, 7'd0, 0, 0, 1, 16'h0));
        vecs.push_back(vz("rst_then_pop", 0, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(vz("lf_long",      0, 0, 16'hAF73, 0, 0, 1));
        vecs.push_back(v ("lf_imm",       0, 0, 16'h1234, 0, 0, 2, 0, 1, 1, 7'h57, 5, 6, 3, 16'h1234));
        vecs.push_back(v ("lf_a",         0, 0, WA,       0, 0, 3, 0, 1, 1, 7'h57, 5, 6, 3, 16'h1234));
        vecs.push_back(v ("lf_b_full",    0, 0, WB,       0, 0, 4, 1, 1, 1, 7'h57, 5, 6, 3, 16'h1234));
        vecs.push_back(v ("lf_pop2_push", 0, 0, WC,       1, 0, 3, 0, 1, 0, 7'd1, 0, 0, 1, 16'h0));
        vecs.push_back(vz("lf_flush",     0, 1, 16'h0000, 0, 1, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].nld, vecs[i].din, vecs[i].nxt, vecs[i].fl);
            check_outputs(vecs[i].name, vecs[i].cnt, vecs[i].full, vecs[i].vld, vecs[i].lng,
                          vecs[i].opc, vecs[i].o0, vecs[i].o1, vecs[i].o2, vecs[i].imm);
        end

        // Random traffic: pushes slightly favoured so the queue regularly fills.
        for (int i = 0; i < 1500; i++) begin
            logic r_rst, r_fl, r_nld, r_nxt;
            logic [15:0] r_din;
            r_rst = ($urandom_range(63) == 0);
            r_fl  = ($urandom_range(15) == 0);
            r_nld = ($urandom_range(9) < 4);
            r_nxt = ($urandom_range(1) == 1);
            r_din = 16'($urandom());
            step(r_rst, r_nld, r_din, r_nxt, r_fl);
            check_model($sformatf("rand[%0d]", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 16, instruction word width.
- OPCODE_W, 7, opcode field width.
- OPER_W, 3, width of each operand field.
- DEPTH, 4, queue depth in words; power of two, >= 2.
REQ-002 The block SHALL reject elaboration unless OPCODE_W + 3*OPER_W == WIDTH.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- notLoad, in, 1, active-low write strobe for data.
- data, in, WIDTH, instruction word to enqueue.
- next, in, 1, consume the head instruction.
- flush, in, 1, discard all queued words.
- full, out, 1, count == DEPTH.
- count, out, clog2(DEPTH+1), number of words held.
- valid, out, 1, a complete head instruction is present.
- isLong, out, 1, the head instruction carries an immediate word.
- opcode, out, OPCODE_W, head opcode field.
- op0, out, OPER_W, head operand 0.
- op1, out, OPER_W, head operand 1.
- op2, out, OPER_W, head operand 2.
- imm, out, WIDTH, immediate word of a long head instruction.

Function
REQ-004 The block SHALL be a circular word FIFO with a read pointer, a write pointer and a count; pointers wrap modulo DEPTH.
REQ-005 Word layout SHALL be:
- opcode = bits [WIDTH-1 : WIDTH-OPCODE_W];
- op0, op1, op2 = the following OPER_W-bit fields, in descending order; op2 occupies the LSBs.
REQ-006 An instruction SHALL be long when bit WIDTH-1 of its head word is 1; its immediate is the next queued word.
REQ-007 Output validity:
- valid = 1 when count >= 1 and the head is short;
- valid = 1 when count >= 2 and the head is long;
- otherwise valid = 0.
REQ-008 Output values (combinational from queue state):
- While valid = 1: opcode/op0/op1/op2 decode the head word, and isLong reflects REQ-006.
- imm = the word after the head when the instruction is long; imm = 0 when it is short.
- While valid = 0: opcode, op0, op1, op2, imm and isLong SHALL all be 0.
REQ-009 Push: notLoad = 0 at a rising edge writes data at the write pointer and increments it, provided the push is accepted (REQ-011).
REQ-010 Pop: next = 1 at a rising edge with valid = 1 advances the read pointer by 1 (short) or 2 (long) and reduces count accordingly.
- next with valid = 0 SHALL be ignored.
REQ-011 Push acceptance:
- A push is accepted when count minus the same-cycle pop size is < DEPTH.
- A push while full with no pop SHALL be dropped, with no state change.
- A simultaneous push and pop when full SHALL both take effect.
REQ-012 Simultaneous push and pop when not full: both take effect; count changes by +1 - popsize.
REQ-013 Flush: flush = 1 sets count and both pointers to 0 at the edge.
- Flush has priority over push and pop in the same cycle; that cycle's push is discarded.
REQ-014 Latency:
- A pushed word is visible on the outputs the cycle after the edge that writes it.
- There is no bypass from data to the outputs.
REQ-015 A long head with only one word queued SHALL hold valid = 0 until its immediate arrives; next is ignored meanwhile.

Reset
REQ-016 When reset = 1 at a rising edge, count, read pointer and write pointer SHALL become 0, so all outputs are 0.
REQ-017 Reset SHALL have priority over flush, push and pop in the same cycle.
REQ-018 Stored word contents need not be cleared by reset.
REQ-019 Reset asserted mid-operation SHALL discard all queued words, including a half-received long instruction.

Verification (WIDTH=16, DEPTH=4)
REQ-020 Short instruction: push 0x5773 (0b0101011_101_110_011) with notLoad low for one edge.
- Next cycle: valid = 1, opcode = 0x2B, op0 = 5, op1 = 6, op2 = 3, isLong = 0, imm = 0, count = 1.
REQ-021 Long instruction: push 0xAF73, then 0x1234.
- After the first edge: valid = 0, count = 1.
- After the second edge: valid = 1, isLong = 1, opcode = 0x57, imm = 0x1234.
- next for one edge: count = 0, valid = 0.
REQ-022 Full and wrap-around: push 4 short words A, B, C, D, then push E without next.
- full = 1, count = 4; E is dropped.
- Then push E with next in the same edge: head = B, count = 4.
- Pop all: the remaining order is B, C, D, E, with the pointers wrapped.
REQ-023 Flush priority: with 3 words queued, assert flush, notLoad = 0 and next in the same edge.
- Result: count = 0, valid = 0, all fields 0.
REQ-024 Reset mid-operation: with one long head word queued, assert reset together with a push of its immediate.
- Result: count = 0, valid = 0.
- A following push of 0x0001 yields opcode = 0, op2 = 1, count = 1.
REQ-025 next with valid = 0: queue empty, or a long head lacking its immediate, with next asserted.
- Result: count unchanged, read pointer unchanged.
